// File: rtl/pio_edge_servicer_pkg.sv
// Shared definitions for the key-PIO edge servicer: PIO register map,
// Avalon bus widths and the servicer FSM states.
package pio_edge_servicer_pkg;

    localparam int unsigned AV_ADDR_W = 2;
    localparam int unsigned AV_DATA_W = 32;

    localparam logic [AV_ADDR_W-1:0] PIO_OFS_DATA     = 2'd0;
    localparam logic [AV_ADDR_W-1:0] PIO_OFS_IRQ_MASK = 2'd2;
    localparam logic [AV_ADDR_W-1:0] PIO_OFS_EDGE_CAP = 2'd3;

    // readdata follows the presented address by this many cycles
    localparam int unsigned PIO_RD_LAT = 1;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_CLR     = 3'd4,
        ST_EMIT    = 3'd5
    } svc_state_e;

endpackage

// File: rtl/pio_edge_servicer.sv
// Avalon-MM initiator that arms the key PIO irq mask, then on each irq reads
// and clears edge_capture and hands the captured bits out as a valid/ready event.
module pio_edge_servicer
    import pio_edge_servicer_pkg::*;
#(
    parameter int unsigned         DATA_W        = 4,
    parameter logic [DATA_W-1:0]   IRQ_MASK_INIT = DATA_W'(4'hF),
    parameter int unsigned         CNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   irq,
    output logic [AV_ADDR_W-1:0]   address,
    output logic                   chipselect,
    output logic                   write_n,
    output logic [AV_DATA_W-1:0]   writedata,
    input  logic [AV_DATA_W-1:0]   readdata,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [DATA_W-1:0]      evt_bits,
    output logic [CNT_W-1:0]       evt_count,
    output logic                   init_done
);

    svc_state_e             r_state;
    logic [AV_ADDR_W-1:0]   r_address;
    logic                   r_chipselect;
    logic                   r_write_n;
    logic [AV_DATA_W-1:0]   r_writedata;
    logic [DATA_W-1:0]      r_cap;
    logic                   r_evt_valid;
    logic [DATA_W-1:0]      r_evt_bits;
    logic [CNT_W-1:0]       r_evt_count;
    logic                   r_init_done;

    logic [DATA_W-1:0]      w_rd_edges;
    logic [AV_DATA_W-1:0]   w_unused_rdata;

    assign w_rd_edges     = readdata[DATA_W-1:0];
    assign w_unused_rdata = readdata;

    // Bus outputs are registered on the edge that enters a state, so the
    // access is on the bus during that state. The INIT write is launched as
    // INIT exits, since reset must leave the bus idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_INIT;
            r_address    <= '0;
            r_chipselect <= 1'b0;
            r_write_n    <= 1'b1;
            r_writedata  <= '0;
            r_cap        <= '0;
            r_evt_valid  <= 1'b0;
            r_evt_bits   <= '0;
            r_evt_count  <= '0;
            r_init_done  <= 1'b0;
        end else begin
            r_address    <= '0;
            r_chipselect <= 1'b0;
            r_write_n    <= 1'b1;
            r_writedata  <= '0;

            case (r_state)
                ST_INIT: begin
                    r_chipselect <= 1'b1;
                    r_write_n    <= 1'b0;
                    r_address    <= PIO_OFS_IRQ_MASK;
                    r_writedata  <= AV_DATA_W'(IRQ_MASK_INIT);
                    r_init_done  <= 1'b1;
                    r_state      <= ST_IDLE;
                end

                ST_IDLE: begin
                    if (irq) begin
                        r_chipselect <= 1'b1;
                        r_address    <= PIO_OFS_EDGE_CAP;
                        r_state      <= ST_RD_ADDR;
                    end
                end

                ST_RD_ADDR: begin
                    r_state <= ST_RD_DATA;
                end

                // A zero capture means a spurious irq: nothing to clear or report
                ST_RD_DATA: begin
                    r_cap <= w_rd_edges;
                    if (w_rd_edges == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_chipselect <= 1'b1;
                        r_write_n    <= 1'b0;
                        r_address    <= PIO_OFS_EDGE_CAP;
                        r_writedata  <= '0;
                        r_state      <= ST_CLR;
                    end
                end

                ST_CLR: begin
                    r_evt_bits  <= r_cap;
                    r_evt_valid <= 1'b1;
                    r_state     <= ST_EMIT;
                end

                // irq is deliberately ignored here; new edges merge in the PIO
                ST_EMIT: begin
                    if (evt_ready) begin
                        r_evt_valid <= 1'b0;
                        if (r_evt_count != '1) begin
                            r_evt_count <= r_evt_count + CNT_W'(1);
                        end
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign address    = r_address;
    assign chipselect = r_chipselect;
    assign write_n    = r_write_n;
    assign writedata  = r_writedata;
    assign evt_valid  = r_evt_valid;
    assign evt_bits   = r_evt_bits;
    assign evt_count  = r_evt_count;
    assign init_done  = r_init_done;

endmodule

// File: tb/tb_pio_edge_servicer.sv
// Bench for pio_edge_servicer: behavioural key PIO slave, event scoreboard
// and directed plus randomized key-press stimulus.
module tb_pio_edge_servicer;
    import pio_edge_servicer_pkg::*;

    localparam int unsigned DW = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           irq;
    logic [1:0]     address;
    logic           chipselect;
    logic           write_n;
    logic [31:0]    writedata;
    logic [31:0]    readdata;
    logic           evt_valid;
    logic           evt_ready;
    logic [DW-1:0]  evt_bits;
    logic [CW-1:0]  evt_count;
    logic           init_done;

    always #5 clk = ~clk;

    pio_edge_servicer #(
        .DATA_W        (DW),
        .IRQ_MASK_INIT (4'hF),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq        (irq),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_bits   (evt_bits),
        .evt_count  (evt_count),
        .init_done  (init_done)
    );

    // Key PIO slave: rising edges of in_port set edge_capture bits, any write
    // to offset 3 clears them, reads are registered (1-cycle latency).
    logic [3:0] in_port, in_prev, edge_cap, irq_mask, rd_last;
    logic       force_irq;

    always @(posedge clk) begin : pio_model
        logic [3:0] e;
        if (!reset_n) begin
            irq_mask <= 4'h0;
            edge_cap <= 4'h0;
            readdata <= 32'h0;
            rd_last  <= 4'h0;
            in_prev  <= in_port;
        end else begin
            e = edge_cap;
            if (chipselect && !write_n && address == PIO_OFS_EDGE_CAP) e = 4'h0;
            if (chipselect && !write_n && address == PIO_OFS_IRQ_MASK) irq_mask <= writedata[3:0];
            edge_cap <= e | (in_port & ~in_prev);
            in_prev  <= in_port;
            if (chipselect && write_n) begin
                case (address)
                    PIO_OFS_DATA:     readdata <= {28'h0, in_port};
                    PIO_OFS_IRQ_MASK: readdata <= {28'h0, irq_mask};
                    PIO_OFS_EDGE_CAP: begin
                        readdata <= {28'h0, edge_cap};
                        rd_last  <= edge_cap;
                    end
                    default:          readdata <= 32'h0;
                endcase
            end
        end
    end

    assign irq = force_irq | (|(edge_cap & irq_mask));

    int n_total = 0;
    int n_bad   = 0;
    int n_rd = 0, n_clr = 0, n_init_wr = 0, n_acc = 0, n_evt = 0;
    int model_cnt = 0;
    int cyc = 0;
    bit cnt_pend = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0;
    logic [3:0] prev_bits;
    logic [3:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every clear write must follow a nonzero capture read, and
    // the value read is the event owed to the consumer, in order.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            model_cnt  = 0;
            cnt_pend   = 1'b0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (cnt_pend) begin
                chk("evt_count", 32'(evt_count), 32'(model_cnt));
                cnt_pend = 1'b0;
            end
            if (prev_valid && !prev_hs) begin
                chk("valid_hold", 32'(evt_valid), 32'd1);
                chk("bits_hold", 32'(evt_bits), 32'(prev_bits));
            end
            if (chipselect) n_acc++;
            if (chipselect && write_n && address == PIO_OFS_EDGE_CAP) n_rd++;
            if (chipselect && !write_n && address == PIO_OFS_IRQ_MASK) n_init_wr++;
            if (chipselect && !write_n && address == PIO_OFS_EDGE_CAP) begin
                n_clr++;
                chk("clr_after_nz_read", 32'(rd_last != 4'h0), 32'd1);
                chk("clr_wdata", writedata, 32'h0);
                exp_q.push_back(rd_last);
            end
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    chk("evt_unexpected", 32'(evt_bits), 32'h0);
                end else begin
                    chk("evt_bits", 32'(evt_bits), 32'(exp_q.pop_front()));
                end
                n_evt++;
                if (model_cnt < int'(CNT_MAX)) model_cnt++;
                cnt_pend = 1'b1;
            end
            prev_valid = evt_valid;
            prev_hs    = evt_valid && evt_ready;
            prev_bits  = evt_bits;
        end
    end

    task automatic wait_valid(input int max_cyc, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (evt_valid) seen = 1'b1;
        end
        if (!seen) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic press(input logic [3:0] k);
        @(posedge clk); #1 in_port = k;
        @(posedge clk); #1 in_port = 4'h0;
    endtask

    task automatic handshake();
        @(posedge clk); #1 evt_ready = 1'b1;
        @(posedge clk); #1 evt_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s_rd, s_clr, s_acc, s_wr, s_evt, t_irq, t_val;
        bit seen;

        reset_n   = 1'b0;
        evt_ready = 1'b0;
        in_port   = 4'h0;
        force_irq = 1'b0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_cs",    32'(chipselect), 32'd0);
        chk("rst_wn",    32'(write_n),    32'd1);
        chk("rst_addr",  32'(address),    32'd0);
        chk("rst_wdata", writedata,       32'd0);
        chk("rst_valid", 32'(evt_valid),  32'd0);
        chk("rst_bits",  32'(evt_bits),   32'd0);
        chk("rst_cnt",   32'(evt_count),  32'd0);
        chk("rst_init",  32'(init_done),  32'd0);
        reset_n = 1'b1;

        // irq_mask programmed exactly once
        repeat (6) @(negedge clk);
        chk("init_writes", 32'(n_init_wr), 32'd1);
        chk("init_mask",   32'(irq_mask),  32'hF);
        chk("init_done",   32'(init_done), 32'd1);
        chk("init_idle",   32'(chipselect), 32'd0);

        // key1 press: latency irq -> evt_valid is 4 cycles
        s_rd = n_rd; s_clr = n_clr;
        @(posedge clk); #1 in_port = 4'h2;
        seen = 1'b0; t_irq = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (irq) begin seen = 1'b1; t_irq = cyc; end
        end
        if (!seen) chk("irq_tmo", 32'd0, 32'd1);
        in_port = 4'h0;
        seen = 1'b0; t_val = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (evt_valid) begin seen = 1'b1; t_val = cyc; end
        end
        if (!seen) chk("valid_tmo", 32'd0, 32'd1);
        chk("latency",   32'(t_val - t_irq), 32'd4);
        chk("key1_bits", 32'(evt_bits), 32'h2);
        chk("key1_rd",   32'(n_rd - s_rd),   32'd1);
        chk("key1_clr",  32'(n_clr - s_clr), 32'd1);
        handshake();
        @(negedge clk); @(negedge clk);
        chk("key1_cnt",  32'(evt_count), 32'd1);

        // backpressure: edges merge in the PIO while an event is held
        press(4'h4);
        wait_valid(20, "bp_first_tmo");
        chk("bp_first_bits", 32'(evt_bits), 32'h4);
        s_acc = n_acc;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            case (i)
                5:       in_port = 4'h1;
                20:      in_port = 4'h8;
                default: in_port = 4'h0;
            endcase
        end
        @(negedge clk);
        chk("bp_no_bus", 32'(n_acc - s_acc), 32'd0);
        chk("bp_bits",   32'(evt_bits), 32'h4);
        chk("bp_valid",  32'(evt_valid), 32'd1);
        handshake();
        wait_valid(20, "bp_merge_tmo");
        chk("bp_merged", 32'(evt_bits), 32'h9);
        handshake();
        @(negedge clk); @(negedge clk);
        chk("bp_cnt", 32'(evt_count), 32'd3);

        // spurious irq: read, no clear, no event
        s_rd = n_rd; s_clr = n_clr; s_evt = n_evt;
        @(posedge clk); #1 force_irq = 1'b1;
        @(posedge clk); #1 force_irq = 1'b0;
        repeat (10) @(negedge clk);
        chk("spur_rd",    32'(n_rd - s_rd),   32'd1);
        chk("spur_clr",   32'(n_clr - s_clr), 32'd0);
        chk("spur_valid", 32'(evt_valid),     32'd0);
        chk("spur_evt",   32'(n_evt - s_evt), 32'd0);

        // reset while an event is pending
        press(4'h1);
        wait_valid(20, "rst_emit_tmo");
        s_wr = n_init_wr;
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(evt_valid),  32'd0);
        chk("arst_cnt",   32'(evt_count),  32'd0);
        chk("arst_cs",    32'(chipselect), 32'd0);
        chk("arst_init",  32'(init_done),  32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rerun_init",  32'(n_init_wr - s_wr), 32'd1);
        chk("rerun_mask",  32'(irq_mask),  32'hF);
        chk("rerun_done",  32'(init_done), 32'd1);
        chk("rerun_valid", 32'(evt_valid), 32'd0);

        // randomized presses with random consumer backpressure
        for (int r = 0; r < 40; r++) begin
            @(posedge clk); #1 in_port = 4'($urandom_range(1, 15));
            @(posedge clk); #1 in_port = 4'h0;
            for (int c = 0; c < int'($urandom_range(2, 10)); c++) begin
                @(posedge clk); #1 evt_ready = 1'($urandom % 2);
            end
        end
        @(posedge clk); #1 evt_ready = 1'b1;
        repeat (40) @(negedge clk);
        chk("drain_q",     32'(exp_q.size()), 32'd0);
        chk("drain_valid", 32'(evt_valid),    32'd0);

        // counter saturates while events keep flowing
        s_evt = n_evt;
        for (int i = 0; i < 20; i++) begin
            press(4'(1 << (i % 4)));
            wait_valid(20, "sat_tmo");
            repeat (2) @(posedge clk);
        end
        repeat (4) @(negedge clk);
        chk("sat_events", 32'(n_evt - s_evt), 32'd20);
        chk("sat_cnt",    32'(evt_count), 32'(CNT_MAX));
        evt_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
